// File: rtl/mem_walk_pkg.sv
// Shared types and constants for the memTest walking-ones sequencer.
package mem_walk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StCheck,
        StDone,
        StFail
    } t_walk_state;

    localparam int unsigned c_PATTERN_SEED = 1;
    localparam int unsigned c_NUM_PASSES   = 2;

endpackage

// File: rtl/comparator.sv
// Equality comparator datapath shared across the memTest blocks.
module comparator #(
    parameter int unsigned p_WIDTH = 8
) (
    input  logic [p_WIDTH-1:0] i_A,
    input  logic [p_WIDTH-1:0] i_B,
    output logic               o_EQUAL
);

    assign o_EQUAL = (i_A == i_B);

endmodule

// File: rtl/mem_walk_ctrl.sv
// Two-pass walking-ones memory test sequencer: writes a range, reads it back and
// reports pass, or the first failing address with expected and read words.
module mem_walk_ctrl
    import mem_walk_pkg::*;
#(
    parameter int unsigned p_AWIDTH = 8,
    parameter int unsigned p_DWIDTH = 8
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_START,
    input  logic [p_AWIDTH-1:0] i_LAST_ADDR,
    output logic [p_AWIDTH-1:0] o_MEM_ADDR,
    output logic [p_DWIDTH-1:0] o_MEM_WDATA,
    output logic                o_MEM_WE,
    output logic                o_MEM_RE,
    input  logic [p_DWIDTH-1:0] i_MEM_RDATA,
    output logic                o_BUSY,
    output logic                o_DONE,
    output logic                o_FAIL,
    output logic [p_AWIDTH-1:0] o_ERR_ADDR,
    output logic [p_DWIDTH-1:0] o_ERR_EXP,
    output logic [p_DWIDTH-1:0] o_ERR_ACT
);

    localparam logic [p_DWIDTH-1:0] c_SEED      = p_DWIDTH'(c_PATTERN_SEED);
    localparam logic                c_LAST_PASS = 1'(c_NUM_PASSES - 1);

    t_walk_state         state_q, state_d;
    logic [p_AWIDTH-1:0] addr_q, last_q;
    logic [p_DWIDTH-1:0] pattern_q, exp_word, pattern_rot;
    logic                pass_q;
    logic                done_q, fail_q;
    logic [p_AWIDTH-1:0] err_addr_q;
    logic [p_DWIDTH-1:0] err_exp_q, err_act_q;
    logic                addr_eq, data_eq, start_ok;

    assign exp_word    = pattern_q ^ {p_DWIDTH{pass_q}};
    assign pattern_rot = {pattern_q[p_DWIDTH-2:0], pattern_q[p_DWIDTH-1]};
    assign start_ok    = i_START && (state_q == StIdle || state_q == StDone || state_q == StFail);

    comparator #(.p_WIDTH(p_AWIDTH)) u_addr_cmp (
        .i_A     (addr_q),
        .i_B     (last_q),
        .o_EQUAL (addr_eq)
    );

    comparator #(.p_WIDTH(p_DWIDTH)) u_data_cmp (
        .i_A     (i_MEM_RDATA),
        .i_B     (exp_word),
        .o_EQUAL (data_eq)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StFail: if (start_ok) state_d = StWrite;
            StWrite: if (addr_eq) state_d = StRead;
            StRead:  state_d = StCheck;
            StCheck: begin
                if (!data_eq)                 state_d = StFail;
                else if (!addr_eq)            state_d = StRead;
                else if (pass_q != c_LAST_PASS) state_d = StWrite;
                else                          state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_MEM_ADDR  = '0;
        o_MEM_WDATA = '0;
        o_MEM_WE    = 1'b0;
        o_MEM_RE    = 1'b0;
        o_BUSY      = 1'b0;
        unique case (state_q)
            StWrite: begin
                o_MEM_WE    = 1'b1;
                o_MEM_ADDR  = addr_q;
                o_MEM_WDATA = exp_word;
                o_BUSY      = 1'b1;
            end
            StRead: begin
                o_MEM_RE   = 1'b1;
                o_MEM_ADDR = addr_q;
                o_BUSY     = 1'b1;
            end
            StCheck: o_BUSY = 1'b1;
            default: ;
        endcase
    end

    // Address counter, pattern rotator, pass bit and status/error capture.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            addr_q     <= '0;
            last_q     <= '0;
            pattern_q  <= '0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StFail: begin
                    if (start_ok) begin
                        last_q     <= i_LAST_ADDR;
                        addr_q     <= '0;
                        pass_q     <= 1'b0;
                        pattern_q  <= c_SEED;
                        done_q     <= 1'b0;
                        fail_q     <= 1'b0;
                        err_addr_q <= '0;
                        err_exp_q  <= '0;
                        err_act_q  <= '0;
                    end
                end
                StWrite: begin
                    if (addr_eq) begin
                        addr_q    <= '0;
                        pattern_q <= c_SEED;
                    end else begin
                        addr_q    <= addr_q + p_AWIDTH'(1);
                        pattern_q <= pattern_rot;
                    end
                end
                StCheck: begin
                    if (!data_eq) begin
                        err_addr_q <= addr_q;
                        err_exp_q  <= exp_word;
                        err_act_q  <= i_MEM_RDATA;
                        fail_q     <= 1'b1;
                    end else if (!addr_eq) begin
                        addr_q    <= addr_q + p_AWIDTH'(1);
                        pattern_q <= pattern_rot;
                    end else if (pass_q != c_LAST_PASS) begin
                        pass_q    <= 1'b1;
                        addr_q    <= '0;
                        pattern_q <= c_SEED;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_DONE     = done_q;
    assign o_FAIL     = fail_q;
    assign o_ERR_ADDR = err_addr_q;
    assign o_ERR_EXP  = err_exp_q;
    assign o_ERR_ACT  = err_act_q;

endmodule

// File: tb/tb_mem_walk_ctrl.sv
// Scoreboard bench for mem_walk_ctrl: an 8-bit and a 4-bit instance, each with a memory model.
module tb_mem_walk_ctrl;

    logic clk = 1'b0;
    logic rst, start;
    logic [3:0] last_addr;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // DUT A: AW=4, DW=8
    logic [3:0] a_addr, a_err_addr;
    logic [7:0] a_wdata, a_rdata, a_err_exp, a_err_act;
    logic       a_we, a_re, a_busy, a_done, a_fail;
    logic [7:0] mem_a [16];
    bit         stuck_en = 1'b0;

    mem_walk_ctrl #(.p_AWIDTH(4), .p_DWIDTH(8)) u_dut_a (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_START     (start),
        .i_LAST_ADDR (last_addr),
        .o_MEM_ADDR  (a_addr),
        .o_MEM_WDATA (a_wdata),
        .o_MEM_WE    (a_we),
        .o_MEM_RE    (a_re),
        .i_MEM_RDATA (a_rdata),
        .o_BUSY      (a_busy),
        .o_DONE      (a_done),
        .o_FAIL      (a_fail),
        .o_ERR_ADDR  (a_err_addr),
        .o_ERR_EXP   (a_err_exp),
        .o_ERR_ACT   (a_err_act)
    );

    // Bit 3 of address 3 can be made stuck at 0.
    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= (stuck_en && a_addr == 4'd3) ? (a_wdata & 8'hF7) : a_wdata;
        if (a_re) a_rdata <= mem_a[a_addr];
    end

    // DUT B: AW=4, DW=4, shares control inputs
    logic [3:0] b_addr, b_err_addr, b_wdata, b_rdata, b_err_exp, b_err_act;
    logic       b_we, b_re, b_busy, b_done, b_fail;
    logic [3:0] mem_b [16];

    mem_walk_ctrl #(.p_AWIDTH(4), .p_DWIDTH(4)) u_dut_b (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_START     (start),
        .i_LAST_ADDR (last_addr),
        .o_MEM_ADDR  (b_addr),
        .o_MEM_WDATA (b_wdata),
        .o_MEM_WE    (b_we),
        .o_MEM_RE    (b_re),
        .i_MEM_RDATA (b_rdata),
        .o_BUSY      (b_busy),
        .o_DONE      (b_done),
        .o_FAIL      (b_fail),
        .o_ERR_ADDR  (b_err_addr),
        .o_ERR_EXP   (b_err_exp),
        .o_ERR_ACT   (b_err_act)
    );

    always @(posedge clk) begin
        if (b_we) mem_b[b_addr] <= b_wdata;
        if (b_re) b_rdata <= mem_b[b_addr];
    end

    logic [11:0] exp_q [$];
    logic [7:0]  exp_b [$];

    task automatic push_walk(input int last, input int passes);
        logic [7:0] d;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i <= last; i++) begin
                d = 8'(1 << (i % 8));
                if (p == 1) d = ~d;
                exp_q.push_back({4'(i), d});
            end
    endtask

    task automatic do_start(input logic [3:0] last);
        @(negedge clk);
        start = 1'b1;
        last_addr = last;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs cycles k_from..k_to after start; pops expected writes; stops on DONE/FAIL.
    task automatic run_a(input int k_from, input int k_to, output int end_cyc);
        logic [11:0] e;
        int bad;
        bad = 0;
        end_cyc = -1;
        for (int k = k_from; k <= k_to; k++) begin
            @(negedge clk);
            if (a_we && a_re) bad++;
            if (a_we) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL write_unexpected cyc=%0d got addr=%0h data=%02h required none",
                             k, a_addr, a_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({a_addr, a_wdata} !== e)
                        $display("FAIL write_seq cyc=%0d got %0h/%02h required %0h/%02h",
                                 k, a_addr, a_wdata, e[11:8], e[7:0]);
                    else n_pass++;
                end
            end
            if (a_done || a_fail) begin
                end_cyc = k;
                break;
            end
            if (!a_busy) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL strobe_busy got %0d bad cycles required 0", bad);
        else n_pass++;
    endtask

    task automatic check_end(input string name, input int got, input int req, input logic fail_req);
        n_total++;
        if (got !== req || a_fail !== fail_req || a_done !== !fail_req || a_busy !== 1'b0)
            $display("FAIL %s got cyc=%0d done=%b fail=%b busy=%b required cyc=%0d fail=%b",
                     name, got, a_done, a_fail, a_busy, req, fail_req);
        else n_pass++;
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL %s_queue got %0d left required 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        last_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({a_we, a_re, a_busy, a_done, a_fail, a_addr, a_wdata, a_err_addr, a_err_exp, a_err_act}
            !== '0)
            $display("FAIL reset_outputs got we=%b re=%b busy=%b done=%b fail=%b required all 0",
                     a_we, a_re, a_busy, a_done, a_fail);
        else n_pass++;
    endtask

    task automatic test_walk;
        int ec;
        push_walk(3, 2);
        do_start(4'd3);
        run_a(1, 40, ec);
        check_end("walk_last3", ec, 25, 1'b0);
        repeat (3) @(negedge clk);
        n_total++;
        if (a_done !== 1'b1 || a_err_addr !== 4'd0 || a_err_exp !== 8'd0)
            $display("FAIL done_hold got done=%b err_addr=%0h required done=1 err=0",
                     a_done, a_err_addr);
        else n_pass++;
    endtask

    task automatic test_last_zero;
        int ec;
        push_walk(0, 2);
        do_start(4'd0);
        run_a(1, 20, ec);
        check_end("walk_last0", ec, 7, 1'b0);
    endtask

    task automatic test_stuck_bit;
        int ec, strobes;
        stuck_en = 1'b1;
        push_walk(7, 1);
        do_start(4'd7);
        run_a(1, 40, ec);
        check_end("stuck_fail", ec, 17, 1'b1);
        n_total++;
        if (a_err_addr !== 4'd3 || a_err_exp !== 8'h08 || a_err_act !== 8'h00)
            $display("FAIL stuck_err got addr=%0h exp=%02h act=%02h required 3/08/00",
                     a_err_addr, a_err_exp, a_err_act);
        else n_pass++;
        strobes = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_we || a_re) strobes++;
        end
        n_total++;
        if (strobes !== 0 || a_fail !== 1'b1)
            $display("FAIL stuck_quiet got strobes=%0d fail=%b required 0/1", strobes, a_fail);
        else n_pass++;
        stuck_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        int ec, strobes;
        push_walk(3, 2);
        do_start(4'd3);
        run_a(1, 19, ec);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        strobes = 0;
        @(negedge clk);
        n_total++;
        if ({a_we, a_re, a_busy, a_done, a_fail, a_addr, a_wdata, a_err_addr, a_err_exp, a_err_act}
            !== '0 || ec !== -1)
            $display("FAIL reset_mid got we=%b re=%b busy=%b done=%b ec=%0d required all 0",
                     a_we, a_re, a_busy, a_done, ec);
        else n_pass++;
        repeat (4) begin
            @(negedge clk);
            if (a_we || a_re || a_busy) strobes++;
        end
        n_total++;
        if (strobes !== 0) $display("FAIL reset_quiet got %0d required 0", strobes);
        else n_pass++;
        push_walk(3, 2);
        do_start(4'd3);
        run_a(1, 40, ec);
        check_end("after_reset", ec, 25, 1'b0);
    endtask

    task automatic test_back_to_back;
        int ec;
        push_walk(3, 2);
        do_start(4'd3);
        run_a(1, 4, ec);
        start = 1'b1;
        last_addr = 4'd9;
        @(posedge clk);
        #1 start = 1'b0;
        run_a(5, 40, ec);
        check_end("start_busy", ec, 25, 1'b0);
        push_walk(1, 2);
        do_start(4'd1);
        @(negedge clk);
        n_total++;
        if (a_done !== 1'b0 || a_busy !== 1'b1)
            $display("FAIL restart_clear got done=%b busy=%b required 0/1", a_done, a_busy);
        else n_pass++;
        exp_q.pop_front();
        run_a(2, 30, ec);
        check_end("restart_done", ec, 13, 1'b0);
    endtask

    task automatic test_wrap;
        int ec;
        logic [3:0] d;
        logic [7:0] e;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i <= 5; i++) begin
                d = 4'(1 << (i % 4));
                if (p == 1) d = ~d;
                exp_b.push_back({4'(i), d});
            end
        do_start(4'd5);
        ec = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (b_we) begin
                n_total++;
                e = (exp_b.size() != 0) ? exp_b.pop_front() : 8'hxx;
                if ({b_addr, b_wdata} !== e)
                    $display("FAIL wrap_write cyc=%0d got %0h/%0h required %0h/%0h",
                             k, b_addr, b_wdata, e[7:4], e[3:0]);
                else n_pass++;
            end
            if (b_done || b_fail) begin
                ec = k;
                break;
            end
        end
        n_total++;
        if (ec !== 37 || b_done !== 1'b1 || b_fail !== 1'b0 || exp_b.size() !== 0)
            $display("FAIL wrap_done got cyc=%0d done=%b fail=%b left=%0d required 37/1/0/0",
                     ec, b_done, b_fail, exp_b.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_last_zero();
        test_stuck_bit();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_walk_ctrl.md
# mem_walk_ctrl

Sequencer for the memTest device: runs a two-pass walking-ones test over a memory address range, driving write/read strobes, generating expected data and using the team's `comparator` datapath to detect the end of range and data mismatches. Sits between the test-control registers (start, last address) and the memory under test. It reports busy, pass or fail, and on failure the failing address, expected word and read word.

## Interface
- `p_AWIDTH`, 8: memory address width.
- `p_DWIDTH`, 8: memory data width; must be ≥ 2.
- `i_CLK` in 1: single clock, rising edge.
- `i_RST` in 1: synchronous, active-high reset.
- `i_START` in 1: start pulse; honoured only in IDLE, DONE or FAIL.
- `i_LAST_ADDR` in p_AWIDTH: highest address tested, inclusive; latched on accepted start.
- `o_MEM_ADDR` out p_AWIDTH: memory address.
- `o_MEM_WDATA` out p_DWIDTH: write data.
- `o_MEM_WE` out 1: write strobe, one word per cycle.
- `o_MEM_RE` out 1: read strobe.
- `i_MEM_RDATA` in p_DWIDTH: read data, valid exactly 1 cycle after `o_MEM_RE`.
- `o_BUSY` out 1: test running.
- `o_DONE` out 1: level, test passed; held until next accepted start or reset.
- `o_FAIL` out 1: level, mismatch found; held until next accepted start or reset.
- `o_ERR_ADDR` out p_AWIDTH: failing address.
- `o_ERR_EXP` out p_DWIDTH: expected word at the failure.
- `o_ERR_ACT` out p_DWIDTH: word read at the failure.

## Operation
- Reset: state IDLE; all outputs 0; address, pattern, pass and last-address registers cleared.
- States: IDLE, WRITE, READ, CHECK, DONE, FAIL.
- Accepted start: latch `i_LAST_ADDR`; set addr = 0, pass = 0, pattern = 1 (bit 0 set); clear `o_DONE`, `o_FAIL` and the ERR_* outputs; go to WRITE.
- Expected word: pattern XOR {p_DWIDTH{pass}}. Pass 0 writes a walking one. Pass 1 writes the inverted walking one (walking zero).
- WRITE: `o_MEM_WE`=1, `o_MEM_ADDR`=addr, `o_MEM_WDATA`=expected word.
  - If addr == last (comparator `o_EQUAL`): reset addr to 0 and pattern to 1, then go to READ.
  - Otherwise: addr+1, rotate pattern left by 1, stay in WRITE.
- READ: `o_MEM_RE`=1, `o_MEM_ADDR`=addr; go to CHECK.
- CHECK: compare `i_MEM_RDATA` with the expected word on a second comparator instance (`o_EQUAL`).
  - Mismatch: load ERR_ADDR/ERR_EXP/ERR_ACT, set `o_FAIL`, go to FAIL.
  - Match, addr ≠ last: addr+1, rotate pattern, go to READ.
  - Match, addr == last, pass 0: pass = 1, addr = 0, pattern = 1, go to WRITE.
  - Match, addr == last, pass 1: set `o_DONE`, go to DONE.
- Pattern rotates modulo p_DWIDTH; it wraps bit p_DWIDTH-1 → bit 0. The address counter never passes last, so it never wraps through the address width.
- `o_BUSY`=1 in WRITE, READ and CHECK only. WE and RE are never both high.
- `i_START` in WRITE, READ or CHECK is ignored. There is no abort; `i_RST` is the only abort.
- `i_LAST_ADDR` changes after start have no effect.
- Last address 0: one word per pass; fully legal.
- Last address all-ones: full space is tested; end detection is by equality, not overflow.

## Timing
- Start sampled in cycle 0 → first write strobe in cycle 1.
- With N = last+1: N write cycles, then 2N cycles of read/check per pass. Total busy time is 6N cycles. `o_DONE` rises in cycle 6N+1.
- FAIL entered the cycle after the offending CHECK. ERR_* outputs are valid in the same cycle as `o_FAIL`.
- Reset mid-test: the next cycle is IDLE with all outputs 0. No further strobes are issued.
- Memory outputs (ADDR, WDATA, WE, RE) are driven combinationally from registered state. Status outputs are registered.

## Structure
- Package `mem_walk_pkg`:
  - state enum typedef `t_walk_state`;
  - `c_PATTERN_SEED` = 1;
  - `c_NUM_PASSES` = 2.
- Two instances of the existing `comparator` sub-module:
  - one for address (addr vs last);
  - one for data (rdata vs expected).
- FSM, address counter, pattern rotator and error capture live in `mem_walk_ctrl`. No new sub-module.

## Test plan
- Good memory model, AW=4, DW=8, last=3, start → WE at addrs 0..3 with 0x01,0x02,0x04,0x08; pass 1 writes 0xFE,0xFD,0xFB,0xF7; `o_DONE`=1 at cycle 25; `o_FAIL`=0.
- Last=0 → one write, one read per pass; `o_DONE` at cycle 7.
- DW=4, last=5 → pattern wraps 0x1,0x2,0x4,0x8,0x1,0x2; test passes.
- Memory with bit 3 stuck-at-0 at addr 3, last=7 → FAIL during pass 0: ERR_ADDR=3, ERR_EXP=0x08, ERR_ACT=0x00; no strobes after.
- Reset asserted during the pass-1 READ phase → next cycle all outputs 0; a later start runs a full passing test.
- `i_START` pulsed while busy → ignored, timing unchanged. Start from DONE → DONE cleared, new test runs.
